// File: rtl/system_seq_pkg.sv
// Shared types for the system memory sequencer: FSM state encoding and reset state.
package system_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    SHIFT,
    PRESENT,
    FINISH
  } seq_state_t;

  localparam seq_state_t SEQ_STATE_RESET = IDLE;

endpackage

// File: rtl/system_memory_sequencer_seq_bit_counter.sv
// Cell counter shared by the load and readback phases; flags the final cell of a pass.
module seq_bit_counter #(
  parameter int DATA_SIZE = 5,
  localparam int CNT_W = $clog2(DATA_SIZE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over increment so a phase change never carries a stale count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + CNT_W'(1);
  end

  // The accept made while at_last is high brings the count to DATA_SIZE.
  assign at_last = (cnt == CNT_W'(DATA_SIZE - 1));

endmodule

// File: rtl/system_memory_sequencer.sv
// Job sequencer for SYSTEM_MEMORY_V4: serial load, N generations, serial readback.
// Optional SEQ_LOAD_BYPASS_EN adds SKIP_LOAD to run a job on the resident grid.
module system_memory_sequencer
  import system_seq_pkg::*;
#(
  parameter int DATA_SIZE = 5,
  parameter int GEN_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [GEN_WIDTH-1:0] GENERATIONS,
`ifdef SEQ_LOAD_BYPASS_EN
  input  logic                 SKIP_LOAD,
`endif
  input  logic                 IN_VALID,
  input  logic                 IN_BIT,
  output logic                 IN_READY,
  output logic                 SERIAL_TO_MEM,
  input  logic                 SERIAL_FROM_MEM,
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 OUTPUT_MODE,
  output logic                 OUT_VALID,
  output logic                 OUT_BIT,
  input  logic                 OUT_READY,
  output logic                 BUSY,
  output logic                 DONE
);

  seq_state_t           state;
  logic [GEN_WIDTH-1:0] gen_cnt;
  logic                 bit_last;
  logic                 bit_clr;
  logic                 bit_inc;
  logic                 gen_last;
  logic                 skip_load;

`ifdef SEQ_LOAD_BYPASS_EN
  assign skip_load = SKIP_LOAD;
`else
  assign skip_load = 1'b0;
`endif

  assign gen_last = (gen_cnt == GEN_WIDTH'(1));
  assign bit_inc  = (state == LOAD && IN_VALID) || (state == PRESENT && OUT_READY);
  assign bit_clr  = (state == IDLE && START) ||
                    (state == LOAD && IN_VALID && bit_last) ||
                    (state == RUN && gen_last);

  seq_bit_counter #(.DATA_SIZE(DATA_SIZE)) u_bit_cnt (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (bit_clr),
    .inc     (bit_inc),
    .at_last (bit_last)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= SEQ_STATE_RESET;
      gen_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            gen_cnt <= GENERATIONS;
            if (skip_load)
              state <= (GENERATIONS == '0) ? SHIFT : RUN;
            else
              state <= LOAD;
          end
        end
        LOAD: begin
          if (IN_VALID && bit_last)
            state <= (gen_cnt == '0) ? SHIFT : RUN;
        end
        RUN: begin
          gen_cnt <= gen_cnt - GEN_WIDTH'(1);
          if (gen_last)
            state <= SHIFT;
        end
        SHIFT:   state <= PRESENT;
        PRESENT: begin
          if (OUT_READY)
            state <= bit_last ? FINISH : SHIFT;
        end
        FINISH:  state <= IDLE;
        default: state <= SEQ_STATE_RESET;
      endcase
    end
  end

  // Mode strobes are decoded from a single state, so at most one is ever high.
  always_comb begin
    IN_READY      = 1'b0;
    LOAD_MODE     = 1'b0;
    SERIAL_TO_MEM = 1'b0;
    RUN_MODE      = 1'b0;
    OUTPUT_MODE   = 1'b0;
    OUT_VALID     = 1'b0;
    OUT_BIT       = 1'b0;
    DONE          = 1'b0;
    BUSY          = (state != IDLE);
    case (state)
      LOAD: begin
        IN_READY      = 1'b1;
        LOAD_MODE     = IN_VALID;
        SERIAL_TO_MEM = IN_BIT;
      end
      RUN:     RUN_MODE = 1'b1;
      SHIFT:   OUTPUT_MODE = 1'b1;
      PRESENT: begin
        OUT_VALID = 1'b1;
        OUT_BIT   = SERIAL_FROM_MEM;
      end
      FINISH:  DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_system_memory_sequencer.sv
// Directed bench: sequencer paired with a behavioural 5-cell memory, GRID_IN = 5'b10010.
module tb_system_memory_sequencer;

  localparam logic [4:0] GRID = 5'b10010;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_rst = 1'b0;
  logic       START = 1'b0;
  logic [7:0] GENERATIONS = '0;
  logic       SKIP_LOAD = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_BIT = 1'b0;
  logic       OUT_READY = 1'b0;
  logic       IN_READY, SERIAL_TO_MEM, SERIAL_FROM_MEM, LOAD_MODE, RUN_MODE, OUTPUT_MODE;
  logic       OUT_VALID, OUT_BIT, BUSY, DONE;

  logic [4:0] mem;
  logic       mem_out;

  int checks = 0;
  int errors = 0;

  int load_cnt = 0, run_cnt = 0, omode_cnt = 0, done_cnt = 0, ready_cnt = 0;
  int overlap_cnt = 0, run_bursts = 0, run_cur = 0, run_last = 0;

  logic [4:0] rb;
  logic       stable, tmo;

  always #5 clk = ~clk;

  system_memory_sequencer #(.DATA_SIZE(5), .GEN_WIDTH(8)) dut (
    .CLK             (clk),
    .RESET           (rst),
    .START           (START),
    .GENERATIONS     (GENERATIONS),
`ifdef SEQ_LOAD_BYPASS_EN
    .SKIP_LOAD       (SKIP_LOAD),
`endif
    .IN_VALID        (IN_VALID),
    .IN_BIT          (IN_BIT),
    .IN_READY        (IN_READY),
    .SERIAL_TO_MEM   (SERIAL_TO_MEM),
    .SERIAL_FROM_MEM (SERIAL_FROM_MEM),
    .LOAD_MODE       (LOAD_MODE),
    .RUN_MODE        (RUN_MODE),
    .OUTPUT_MODE     (OUTPUT_MODE),
    .OUT_VALID       (OUT_VALID),
    .OUT_BIT         (OUT_BIT),
    .OUT_READY       (OUT_READY),
    .BUSY            (BUSY),
    .DONE            (DONE)
  );

  // Memory: shift in at LSB, capture grid, rotate MSB out into a registered serial output.
  always_ff @(posedge clk or posedge mem_rst) begin
    if (mem_rst) begin
      mem     <= '0;
      mem_out <= 1'b0;
    end else if (LOAD_MODE) begin
      mem <= {mem[3:0], SERIAL_TO_MEM};
    end else if (RUN_MODE) begin
      mem <= GRID;
    end else if (OUTPUT_MODE) begin
      mem_out <= mem[4];
      mem     <= {mem[3:0], mem[4]};
    end
  end
  assign SERIAL_FROM_MEM = mem_out;

  always @(negedge clk) begin
    if (LOAD_MODE)   load_cnt++;
    if (RUN_MODE)    run_cnt++;
    if (OUTPUT_MODE) omode_cnt++;
    if (DONE)        done_cnt++;
    if (IN_READY)    ready_cnt++;
    if (int'(LOAD_MODE) + int'(RUN_MODE) + int'(OUTPUT_MODE) > 1) overlap_cnt++;
    if (RUN_MODE) run_cur++;
    else if (run_cur != 0) begin
      run_bursts++;
      run_last = run_cur;
      run_cur  = 0;
    end
  end

  task automatic do_job(input logic [4:0] data, input logic [7:0] gens, input int gap_at,
                        input int stall_at, input logic hold_valid,
                        output logic [4:0] rbo, output logic stab, output logic to);
    int   n;
    logic b;
    rbo = '0; stab = 1'b1; to = 1'b0;
    @(posedge clk); #1;
    START = 1'b1; GENERATIONS = gens; IN_VALID = hold_valid; IN_BIT = 1'b0;
    @(posedge clk); #1;
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == gap_at) begin
        IN_VALID = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      IN_VALID = 1'b1; IN_BIT = data[4-i];
      @(posedge clk); #1;
    end
    IN_VALID = hold_valid; IN_BIT = 1'b0;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (!OUT_VALID && n < 40) begin @(posedge clk); #1; n++; end
      if (!OUT_VALID) begin to = 1'b1; break; end
      if (j == stall_at) begin
        OUT_READY = 1'b0; b = OUT_BIT;
        repeat (3) begin
          @(posedge clk); #1;
          if (!OUT_VALID || OUT_BIT !== b) stab = 1'b0;
        end
        OUT_READY = 1'b1;
      end
      rbo[4-j] = OUT_BIT;
      @(posedge clk); #1;
    end
    n = 0;
    while (BUSY && n < 20) begin @(posedge clk); #1; n++; end
    if (BUSY) to = 1'b1;
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rst = 1'b1; OUT_READY = 1'b0;
    #1;
    checks++;
    if ({IN_READY, SERIAL_TO_MEM, LOAD_MODE, RUN_MODE, OUTPUT_MODE, OUT_VALID, OUT_BIT} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000000",
               {IN_READY, SERIAL_TO_MEM, LOAD_MODE, RUN_MODE, OUTPUT_MODE, OUT_VALID, OUT_BIT});
    end
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done got %b%b exp 00", BUSY, DONE);
    end
    checks++;
    if (mem !== 5'b00000) begin errors++; $display("FAIL reset_mem got %b exp 00000", mem); end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; mem_rst = 1'b0; OUT_READY = 1'b1;
  endtask

  task automatic test_basic_job();
    int l0 = load_cnt, r0 = run_cnt, o0 = omode_cnt, d0 = done_cnt;
    do_job(5'b01101, 8'd0, -1, -1, 1'b1, rb, stable, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
    checks++;
    if (load_cnt - l0 != 5) begin errors++; $display("FAIL basic_load_cycles got %0d exp 5", load_cnt - l0); end
    checks++;
    if (run_cnt - r0 != 0) begin errors++; $display("FAIL basic_run_cycles got %0d exp 0", run_cnt - r0); end
    checks++;
    if (omode_cnt - o0 != 5) begin errors++; $display("FAIL basic_output_cycles got %0d exp 5", omode_cnt - o0); end
    checks++;
    if (rb !== 5'b01101) begin errors++; $display("FAIL basic_readback got %b exp 01101", rb); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt - d0); end
    checks++;
    if (mem !== 5'b01101) begin errors++; $display("FAIL basic_mem_end got %b exp 01101", mem); end
  endtask

  task automatic test_stalls();
    int l0 = load_cnt, o0 = omode_cnt, d0 = done_cnt;
    do_job(5'b01101, 8'd0, 2, 2, 1'b0, rb, stable, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL stall_timeout got 1 exp 0"); end
    checks++;
    if (load_cnt - l0 != 5) begin errors++; $display("FAIL stall_load_cycles got %0d exp 5", load_cnt - l0); end
    checks++;
    if (omode_cnt - o0 != 5) begin errors++; $display("FAIL stall_output_cycles got %0d exp 5", omode_cnt - o0); end
    checks++;
    if (!stable) begin errors++; $display("FAIL stall_out_stable got 0 exp 1"); end
    checks++;
    if (rb !== 5'b01101) begin errors++; $display("FAIL stall_readback got %b exp 01101", rb); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL stall_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_generations();
    int r0 = run_cnt, b0 = run_bursts, ov0 = overlap_cnt;
    do_job(5'b01101, 8'd3, -1, -1, 1'b0, rb, stable, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL gen_timeout got 1 exp 0"); end
    checks++;
    if (run_cnt - r0 != 3) begin errors++; $display("FAIL gen_run_cycles got %0d exp 3", run_cnt - r0); end
    checks++;
    if (run_bursts - b0 != 1 || run_last != 3) begin
      errors++; $display("FAIL gen_run_burst got %0d bursts len %0d exp 1 len 3", run_bursts - b0, run_last);
    end
    checks++;
    if (overlap_cnt != ov0) begin errors++; $display("FAIL gen_mode_overlap got %0d exp 0", overlap_cnt - ov0); end
    checks++;
    if (rb !== 5'b10010) begin errors++; $display("FAIL gen_readback got %b exp 10010", rb); end
    checks++;
    if (mem !== 5'b10010) begin errors++; $display("FAIL gen_mem_end got %b exp 10010", mem); end
  endtask

  task automatic test_mid_reset();
    int d0;
    @(posedge clk); #1;
    START = 1'b1; GENERATIONS = 8'd0;
    @(posedge clk); #1;
    START = 1'b0; IN_VALID = 1'b1; IN_BIT = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if ({LOAD_MODE, IN_READY, BUSY} !== 3'b000) begin
      errors++; $display("FAIL midreset_outputs got %b exp 000", {LOAD_MODE, IN_READY, BUSY});
    end
    checks++;
    if (mem !== 5'b01011) begin errors++; $display("FAIL midreset_mem got %b exp 01011", mem); end
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    checks++;
    if (mem !== 5'b01011 || BUSY !== 1'b0) begin
      errors++; $display("FAIL midreset_hold got %b busy %b exp 01011 busy 0", mem, BUSY);
    end
    rst = 1'b0;
    d0 = done_cnt;
    do_job(5'b10110, 8'd0, -1, -1, 1'b0, rb, stable, tmo);
    checks++;
    if (tmo || rb !== 5'b10110) begin
      errors++; $display("FAIL midreset_rejob got %b tmo %b exp 10110 tmo 0", rb, tmo);
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL midreset_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_start_while_busy();
    int d0 = done_cnt, l0 = load_cnt;
    fork
      do_job(5'b00111, 8'd2, -1, -1, 1'b0, rb, stable, tmo);
      begin
        repeat (9) @(posedge clk);
        #3 START = 1'b1;
        @(posedge clk);
        #3 START = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b exp 0", BUSY); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done got %0d exp 1", done_cnt - d0); end
    checks++;
    if (tmo || rb !== 5'b10010) begin
      errors++; $display("FAIL busy_start_readback got %b tmo %b exp 10010 tmo 0", rb, tmo);
    end
    checks++;
    if (load_cnt - l0 != 5) begin errors++; $display("FAIL busy_start_load got %0d exp 5", load_cnt - l0); end
  endtask

`ifdef SEQ_LOAD_BYPASS_EN
  task automatic test_bypass();
    int l0 = load_cnt, q0 = ready_cnt, n;
    logic to = 1'b0;
    logic [4:0] r = '0;
    @(posedge clk); #1;
    START = 1'b1; SKIP_LOAD = 1'b1; GENERATIONS = 8'd2; IN_VALID = 1'b1; IN_BIT = 1'b1;
    @(posedge clk); #1;
    START = 1'b0; SKIP_LOAD = 1'b0;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (!OUT_VALID && n < 40) begin @(posedge clk); #1; n++; end
      if (!OUT_VALID) begin to = 1'b1; break; end
      r[4-j] = OUT_BIT;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1; IN_VALID = 1'b0;
    checks++;
    if (load_cnt - l0 != 0) begin errors++; $display("FAIL bypass_load got %0d exp 0", load_cnt - l0); end
    checks++;
    if (ready_cnt - q0 != 0) begin errors++; $display("FAIL bypass_in_ready got %0d exp 0", ready_cnt - q0); end
    checks++;
    if (to || r !== 5'b10010) begin
      errors++; $display("FAIL bypass_readback got %b tmo %b exp 10010 tmo 0", r, to);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_job();
    test_stalls();
    test_generations();
    test_mid_reset();
    test_start_while_busy();
`ifdef SEQ_LOAD_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
